// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack with peek output, replace-top on simultaneous push/pop,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
module lifo_stack_ctrl #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             ready,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_idx;
    logic             empty_w, full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);
    // Wraps to DEPTH-1 when count is DEPTH and DEPTH is a power of two; unused when empty.
    assign top_idx = count_q[AW-1:0] - AW'(1);

    // NOTE: combinational logic uses blocking '=' with every output defaulted first,
    // so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        count_d     = count_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[AW-1:0];
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;

        case ({push, pop})
            2'b10: begin
                if (full_w) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty_w) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            2'b11: begin
                // Replace-top; on an empty stack this degenerates to a plain push at slot 0.
                wr_en = 1'b1;
                if (empty_w) begin
                    count_d = CW'(1);
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count alone defines which
    // entries are live, and a reset on every word would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out    = empty_w ? '0 : mem_q[top_idx];
    assign valid       = ~empty_w;
    assign ready       = ~full_w;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almost_full = (count_q >= AF_CNT);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
